// File: rtl/psg_register_bank_if.sv
// Host-side AY bus: address/data byte in, BDIR/BC1 bus codes, registered read-back out.
// The host drives the master side and the register bank sits on the slave side.
interface psg_register_bank_if;
  logic [7:0] data_in;
  logic       bdir;
  logic       bc1;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output data_in, bdir, bc1, input data_out, data_oe);
  modport slave  (input data_in, bdir, bc1, output data_out, data_oe);
endinterface

// File: rtl/psg_register_bank.sv
// AY-3-8910-style PSG register file: bus-code decode, chip-selected address latch, masked storage.
// Writes and decoded outputs appear 1 cycle after the write code; read-back data_oe/data_out appear 1 cycle after the read code.
module psg_register_bank #(
  parameter int         NUM_CHANNELS = 3,
  parameter int         TONE_BITS    = 12,
  parameter bit         TOGGLE_MODE  = 1'b0,
  parameter logic [3:0] CHIP_ADDR    = 4'h0
) (
  input  logic                              clk,
  input  logic                              reset,
  psg_register_bank_if.slave                bus,
  output logic [NUM_CHANNELS*TONE_BITS-1:0] tone_period,
  output logic [4:0]                        noise_period,
  output logic [NUM_CHANNELS-1:0]           tone_en_n,
  output logic [NUM_CHANNELS-1:0]           noise_en_n,
  output logic [NUM_CHANNELS*4-1:0]         amplitude,
  output logic [NUM_CHANNELS-1:0]           env_mode,
  output logic [15:0]                       env_period,
  output logic [3:0]                        env_shape,
  output logic                              env_restart
);

  localparam int NUM_REGS    = 3*NUM_CHANNELS + 5;
  localparam int COARSE_BITS = TONE_BITS - 8;
  localparam int R_NOISE     = 2*NUM_CHANNELS;
  localparam int R_MIXER     = R_NOISE + 1;
  localparam int R_AMP       = R_NOISE + 2;
  localparam int R_ENV_F     = 3*NUM_CHANNELS + 2;
  localparam int R_ENV_C     = 3*NUM_CHANNELS + 3;
  localparam int R_SHAPE     = 3*NUM_CHANNELS + 4;

  typedef enum logic {PH_ADDR, PH_DATA} phase_t;

  // Only bits that exist in the real register are ever stored, so read-back needs no masking.
  function automatic logic [7:0] reg_mask(input int a);
    if (a < R_NOISE)     return (a % 2 == 0) ? 8'hFF : 8'((1 << COARSE_BITS) - 1);
    else if (a == R_NOISE) return 8'h1F;
    else if (a == R_MIXER) return 8'((1 << (2*NUM_CHANNELS)) - 1);
    else if (a < R_ENV_F)  return 8'h1F;
    else if (a < R_SHAPE)  return 8'hFF;
    else if (a == R_SHAPE) return 8'h0F;
    else                   return 8'h00;
  endfunction

  logic [7:0] regs [NUM_REGS];
  logic [3:0] addr;
  logic       selected;
  logic [7:0] rd_dat_q;
  logic       rd_vld_q;
  logic [7:0] rd_val;
  logic       do_latch;
  logic       do_write;
  logic       do_read;
  phase_t     phase_q;
  phase_t     phase_d;

  always_ff @(posedge clk) begin
    if (reset) phase_q <= PH_ADDR;
    else       phase_q <= phase_d;
  end

  always_comb begin
    phase_d  = (phase_q == PH_ADDR) ? PH_DATA : PH_ADDR;
    do_latch = 1'b0;
    do_write = 1'b0;
    do_read  = 1'b0;
    if (TOGGLE_MODE) begin
      do_latch = (phase_q == PH_ADDR);
      do_write = (phase_q == PH_DATA) && selected;
    end else begin
      case ({bus.bdir, bus.bc1})
        2'b01:   do_read  = selected;
        2'b10:   do_write = selected;
        2'b11:   do_latch = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(addr) == i) rd_val = regs[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= 4'h0;
      selected    <= 1'b1;
      rd_dat_q    <= 8'h00;
      rd_vld_q    <= 1'b0;
      env_restart <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      rd_vld_q    <= do_read;
      rd_dat_q    <= do_read ? rd_val : 8'h00;
      env_restart <= do_write && (int'(addr) == R_SHAPE);
      if (do_latch) begin
        if (bus.data_in[7:4] == CHIP_ADDR) begin
          addr     <= bus.data_in[3:0];
          selected <= 1'b1;
        end else begin
          selected <= 1'b0;
        end
      end
      for (int i = 0; i < NUM_REGS; i++)
        if (do_write && int'(addr) == i) regs[i] <= bus.data_in & reg_mask(i);
    end
  end

  assign bus.data_out = rd_dat_q;
  assign bus.data_oe  = rd_vld_q;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign tone_period[i*TONE_BITS +: TONE_BITS] = {regs[2*i+1][COARSE_BITS-1:0], regs[2*i]};
    assign amplitude[i*4 +: 4] = regs[R_AMP+i][3:0];
    assign env_mode[i]         = regs[R_AMP+i][4];
  end

  assign noise_period = regs[R_NOISE][4:0];
  assign tone_en_n    = regs[R_MIXER][NUM_CHANNELS-1:0];
  assign noise_en_n   = regs[R_MIXER][2*NUM_CHANNELS-1:NUM_CHANNELS];
  assign env_period   = {regs[R_ENV_C], regs[R_ENV_F]};
  assign env_shape    = regs[R_SHAPE][3:0];

endmodule

// File: tb/tb_psg_register_bank.sv
// Directed bench for psg_register_bank: bus-code table on the default build, hand sequences for toggle mode and reset.
module tb_psg_register_bank;
  logic clk;
  logic rst0;
  logic rst1;

  psg_register_bank_if b0();
  psg_register_bank_if b1();

  logic [35:0] tp0, tp1;
  logic [4:0]  np0, np1;
  logic [2:0]  ten0, ten1, nen0, nen1, em0, em1;
  logic [11:0] amp0, amp1;
  logic [15:0] ep0, ep1;
  logic [3:0]  es0, es1;
  logic        er0, er1;

  psg_register_bank dut (
    .clk(clk), .reset(rst0), .bus(b0),
    .tone_period(tp0), .noise_period(np0), .tone_en_n(ten0), .noise_en_n(nen0),
    .amplitude(amp0), .env_mode(em0), .env_period(ep0), .env_shape(es0), .env_restart(er0)
  );

  psg_register_bank #(.TOGGLE_MODE(1'b1)) dut_t (
    .clk(clk), .reset(rst1), .bus(b1),
    .tone_period(tp1), .noise_period(np1), .tone_en_n(ten1), .noise_en_n(nen1),
    .amplitude(amp1), .env_mode(em1), .env_period(ep1), .env_shape(es1), .env_restart(er1)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] IDL = 2'b00, RD = 2'b01, WR = 2'b10, LT = 2'b11;

  typedef enum {F_NONE, F_TONE0, F_NOISE, F_MIX, F_SHAPE, F_AMP0, F_ENVP} field_t;

  typedef struct {
    logic [1:0]  code;
    logic [7:0]  din;
    logic        exp_oe;
    logic [7:0]  exp_dout;
    logic        exp_rst;
    field_t      fld;
    logic [15:0] fexp;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] c, input logic [7:0] d, input logic oe,
                     input logic [7:0] dout, input logic rs, input field_t f, input logic [15:0] fe);
    vec_t v;
    v.code = c; v.din = d; v.exp_oe = oe; v.exp_dout = dout; v.exp_rst = rs; v.fld = f; v.fexp = fe;
    vecs.push_back(v);
  endtask

  function automatic logic [15:0] fget(input field_t f);
    case (f)
      F_TONE0: return {4'h0, tp0[11:0]};
      F_NOISE: return {11'h0, np0};
      F_MIX:   return {10'h0, nen0, ten0};
      F_SHAPE: return {12'h0, es0};
      F_AMP0:  return {11'h0, em0[0], amp0[3:0]};
      F_ENVP:  return ep0;
      default: return 16'h0;
    endcase
  endfunction

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic cyc0(input logic [1:0] c, input logic [7:0] d);
    b0.bdir = c[1]; b0.bc1 = c[0]; b0.data_in = d;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic cyc1(input logic [7:0] d);
    b1.data_in = d;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_tone"},  tp0, 0);
    check({tag, "_noise"}, np0, 0);
    check({tag, "_en_n"},  {nen0, ten0}, 0);
    check({tag, "_amp"},   {em0, amp0}, 0);
    check({tag, "_env"},   {es0, ep0}, 0);
    check({tag, "_bus"},   {b0.data_oe, b0.data_out, er0}, 0);
  endtask

  initial begin
    clk = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    b0.bdir = 1'b0; b0.bc1 = 1'b0; b0.data_in = 8'h00;
    b1.bdir = 1'b0; b1.bc1 = 1'b1; b1.data_in = 8'h00;

    //   code din    oe dout   rst field    expected field
    add(LT,  8'h00, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'hA5, 0, 8'h00, 0, F_TONE0, 16'h0A5);
    add(LT,  8'h01, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'hFF, 0, 8'h00, 0, F_TONE0, 16'hFA5);
    add(RD,  8'h00, 1, 8'h0F, 0, F_NONE,  16'h0);
    add(IDL, 8'h00, 0, 8'h00, 0, F_NONE,  16'h0);
    add(LT,  8'h06, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'hFF, 0, 8'h00, 0, F_NOISE, 16'h1F);
    add(RD,  8'h00, 1, 8'h1F, 0, F_NONE,  16'h0);
    add(LT,  8'h0E, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h55, 0, 8'h00, 0, F_NOISE, 16'h1F);
    add(RD,  8'h00, 1, 8'h00, 0, F_NONE,  16'h0);
    add(LT,  8'h0D, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h0E, 0, 8'h00, 1, F_SHAPE, 16'hE);
    add(IDL, 8'h00, 0, 8'h00, 0, F_SHAPE, 16'hE);
    add(IDL, 8'h00, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h0E, 0, 8'h00, 1, F_SHAPE, 16'hE);
    add(IDL, 8'h00, 0, 8'h00, 0, F_NONE,  16'h0);
    add(LT,  8'h37, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h3F, 0, 8'h00, 0, F_MIX,   16'h00);
    add(RD,  8'h00, 0, 8'h00, 0, F_NONE,  16'h0);
    add(LT,  8'h07, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h3F, 0, 8'h00, 0, F_MIX,   16'h3F);
    add(RD,  8'h00, 1, 8'h3F, 0, F_NONE,  16'h0);
    add(LT,  8'h08, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h1F, 0, 8'h00, 0, F_AMP0,  16'h1F);
    add(RD,  8'h00, 1, 8'h1F, 0, F_NONE,  16'h0);
    add(LT,  8'h09, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'hFF, 0, 8'h00, 0, F_NONE,  16'h0);
    add(RD,  8'h00, 1, 8'h1F, 0, F_NONE,  16'h0);
    add(LT,  8'h0B, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h34, 0, 8'h00, 0, F_NONE,  16'h0);
    add(LT,  8'h0C, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'h12, 0, 8'h00, 0, F_ENVP,  16'h1234);
    add(LT,  8'h05, 0, 8'h00, 0, F_NONE,  16'h0);
    add(WR,  8'hFF, 0, 8'h00, 0, F_NONE,  16'h0);
    add(RD,  8'h00, 1, 8'h0F, 0, F_NONE,  16'h0);
    add(LT,  8'h0D, 0, 8'h00, 0, F_NONE,  16'h0);
    add(RD,  8'h00, 1, 8'h0E, 0, F_SHAPE, 16'hE);

    @(negedge clk); @(negedge clk);
    check_zero0("reset");
    check("reset_t_tone", tp1, 0);
    check("reset_t_amp", {em1, amp1, ep1}, 0);
    rst0 = 1'b0;

    foreach (vecs[k]) begin
      cyc0(vecs[k].code, vecs[k].din);
      check($sformatf("vec%0d_bus", k), {b0.data_oe, b0.data_out, er0},
            {vecs[k].exp_oe, vecs[k].exp_dout, vecs[k].exp_rst});
      if (vecs[k].fld != F_NONE)
        check($sformatf("vec%0d_field", k), fget(vecs[k].fld), vecs[k].fexp);
    end

    // Reset wins over a write in the same cycle and discards the latched R5.
    cyc0(LT, 8'h05);
    rst0 = 1'b1;
    cyc0(WR, 8'h77);
    check_zero0("midreset");
    rst0 = 1'b0;
    cyc0(WR, 8'h33);
    check("post_reset_r0", tp0[11:0], 12'h033);
    check("post_reset_ch2", tp0[35:24], 12'h000);

    // Toggle mode: bc1 is held at the read code to show bus codes are ignored.
    rst1 = 1'b0;
    cyc1(8'h08); cyc1(8'h1A); cyc1(8'h0B); cyc1(8'h34); cyc1(8'h0C); cyc1(8'h12);
    check("tog_amp0", amp1[3:0], 4'hA);
    check("tog_envmode0", em1[0], 1'b1);
    check("tog_envp", ep1, 16'h1234);
    check("tog_no_read", {b1.data_oe, b1.data_out, er1}, 0);
    cyc1(8'h38); cyc1(8'h05);
    check("tog_deselect", {em1[0], amp1[3:0]}, 5'h1A);
    cyc1(8'h08); cyc1(8'h03);
    check("tog_reselect", {em1[0], amp1[3:0]}, 5'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
